// File: rtl/sha_state_regbank.sv
// SHA-2 state register bank: chaining words H0..H7 and working variables a..h.
// Sequences one message block: load a..h from H, apply ROUNDS round updates
// with externally supplied T1/T2, then accumulate H += a..h modulo 2^WIDTH.
module sha_state_regbank #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64,
  parameter int RW     = $clog2(ROUNDS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               init_i,
  input  logic [8*WIDTH-1:0] iv_i,
  input  logic               blk_start_i,
  input  logic               rnd_en_i,
  input  logic [WIDTH-1:0]   t1_i,
  input  logic [WIDTH-1:0]   t2_i,
  output logic [8*WIDTH-1:0] work_o,
  output logic [8*WIDTH-1:0] hash_o,
  output logic [RW-1:0]      round_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hash_q [8];
  logic [WIDTH-1:0] hash_d [8];
  logic [WIDTH-1:0] work_q [8];
  logic [WIDTH-1:0] work_d [8];
  logic [RW-1:0]    round_q, round_d;
  logic             done_q, done_d;

  // Next-state logic: everything holds unless the current state acts on it.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hash_d[i] = hash_q[i];
      work_d[i] = work_q[i];
    end
    case (state_q)
      IDLE: begin
        if (init_i) begin
          for (int i = 0; i < 8; i++) begin
            hash_d[i] = iv_i[(7-i)*WIDTH +: WIDTH];
          end
        end else if (blk_start_i) begin
          for (int i = 0; i < 8; i++) begin
            work_d[i] = hash_q[i];
          end
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_en_i) begin
          work_d[0] = t1_i + t2_i;
          work_d[1] = work_q[0];
          work_d[2] = work_q[1];
          work_d[3] = work_q[2];
          work_d[4] = work_q[3] + t1_i;
          work_d[5] = work_q[4];
          work_d[6] = work_q[5];
          work_d[7] = work_q[6];
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            state_d = FINAL;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[i] = hash_q[i] + work_q[i];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; an asynchronous reset aborts any block in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      round_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        hash_q[i] <= '0;
        work_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        hash_q[i] <= hash_d[i];
        work_q[i] <= work_d[i];
      end
    end
  end

  // Word 0 (H0 / a) is placed in the most significant slice.
  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign hash_o[(7-g)*WIDTH +: WIDTH] = hash_q[g];
    assign work_o[(7-g)*WIDTH +: WIDTH] = work_q[g];
  end

  assign round_o = round_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_sha_state_regbank.sv
// Testbench for sha_state_regbank (SHA-256 configuration): drives directed
// and random blocks and compares every cycle against a word-level model.
module tb_sha_state_regbank;

  localparam int W = 32;
  localparam int R = 64;

  logic           CLK;
  logic           RST;
  logic           initI;
  logic [8*W-1:0] ivI;
  logic           blkStartI;
  logic           rndEnI;
  logic [W-1:0]   t1I;
  logic [W-1:0]   t2I;
  logic [8*W-1:0] workO;
  logic [8*W-1:0] hashO;
  logic [5:0]     roundO;
  logic           busyO;
  logic           doneO;

  int errors;
  int checks;

  logic [W-1:0] mH [8];
  logic [W-1:0] mW [8];
  int           mRound;
  int           mState;
  bit           mDone;

  logic [W-1:0] wSched [R];

  logic [W-1:0] kConst [R] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [8*W-1:0] IV_256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [8*W-1:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  sha_state_regbank #(.WIDTH(W), .ROUNDS(R)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .init_i      (initI),
    .iv_i        (ivI),
    .blk_start_i (blkStartI),
    .rnd_en_i    (rndEnI),
    .t1_i        (t1I),
    .t2_i        (t2I),
    .work_o      (workO),
    .hash_o      (hashO),
    .round_o     (roundO),
    .busy_o      (busyO),
    .done_o      (doneO)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [8*W-1:0] packWords(input logic [W-1:0] w [8]);
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*W +: W] = w[i];
    return r;
  endfunction

  function automatic logic [8*W-1:0] randWide();
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [8*W-1:0] observed, input logic [8*W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mH[i] = '0;
      mW[i] = '0;
    end
    mRound = 0;
    mState = 0;
    mDone  = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs the DUT samples, then compare.
  task automatic applyStimulus();
    logic [W-1:0] nw [8];
    @(posedge CLK);
    if (RST) begin
      modelReset();
    end else begin
      case (mState)
        0: begin
          mDone = 1'b0;
          if (initI) begin
            for (int i = 0; i < 8; i++) mH[i] = ivI[(7-i)*W +: W];
          end else if (blkStartI) begin
            mW     = mH;
            mRound = 0;
            mState = 1;
          end
        end
        1: begin
          mDone = 1'b0;
          if (rndEnI) begin
            nw[0] = t1I + t2I;
            for (int i = 1; i < 8; i++) nw[i] = mW[i-1];
            nw[4] = mW[3] + t1I;
            mW    = nw;
            if (mRound == R - 1) begin
              mRound = 0;
              mState = 2;
            end else begin
              mRound++;
            end
          end
        end
        default: begin
          for (int i = 0; i < 8; i++) mH[i] = mH[i] + mW[i];
          mState = 0;
          mDone  = 1'b1;
        end
      endcase
    end
    #1;
    checkOutput("work", workO, packWords(mW));
    checkOutput("hash", hashO, packWords(mH));
    checkOutput("round", 256'(roundO), 256'(mRound));
    checkOutput("busy", 256'(busyO), 256'(mState != 0));
    checkOutput("done", 256'(doneO), 256'(mDone));
  endtask

  // T1/T2 generation: 0 zeros, 1 SHA-256 round on the model state, 2 t1=1 t2=0, 3 random.
  task automatic setRoundInputs(input int mode);
    logic [W-1:0] a, b, c, e, f, g, h;
    case (mode)
      1: begin
        a = mW[0]; b = mW[1]; c = mW[2];
        e = mW[4]; f = mW[5]; g = mW[6]; h = mW[7];
        t1I = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g))
              + kConst[mRound] + wSched[mRound];
        t2I = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      end
      2: begin
        t1I = 32'd1;
        t2I = 32'd0;
      end
      3: begin
        t1I = $urandom;
        t2I = $urandom;
      end
      default: begin
        t1I = '0;
        t2I = '0;
      end
    endcase
  endtask

  task automatic startBlock();
    blkStartI = 1'b1;
    rndEnI    = 1'($urandom_range(0, 1));
    applyStimulus();
    blkStartI = 1'b0;
  endtask

  // Run rounds until done_o; lat counts edges including the start edge.
  task automatic finishBlock(input int mode, input int stallAt, input int stallLen, inout int lat);
    int  stalls;
    bit  seen;
    stalls = 0;
    seen   = 1'b0;
    for (int guard = 0; guard < 1000 && !seen; guard++) begin
      if (mode == 3) begin
        rndEnI    = ($urandom_range(0, 3) != 0);
        initI     = ($urandom_range(0, 7) == 0);
        blkStartI = ($urandom_range(0, 7) == 0);
        ivI       = randWide();
      end else if (mState == 1 && mRound == stallAt && stalls < stallLen) begin
        rndEnI = 1'b0;
        stalls++;
      end else begin
        rndEnI = 1'b1;
      end
      setRoundInputs(mode);
      applyStimulus();
      lat++;
      if (doneO === 1'b1) seen = 1'b1;
    end
    initI     = 1'b0;
    blkStartI = 1'b0;
    rndEnI    = 1'b0;
    if (!seen) checkOutput("blockTimeout", 256'(0), 256'(1));
  endtask

  task automatic runBlock(input int mode, input int stallAt, input int stallLen, output int lat);
    startBlock();
    lat = 1;
    finishBlock(mode, stallAt, stallLen, lat);
  endtask

  task automatic loadIv(input logic [8*W-1:0] iv);
    initI = 1'b1;
    ivI   = iv;
    applyStimulus();
    initI = 1'b0;
  endtask

  initial begin
    int lat;
    int guard;
    errors    = 0;
    checks    = 0;
    RST       = 1'b1;
    initI     = 1'b0;
    ivI       = '0;
    blkStartI = 1'b0;
    rndEnI    = 1'b0;
    t1I       = '0;
    t2I       = '0;
    modelReset();

    // Message schedule for the single padded block "abc".
    for (int t = 0; t < 16; t++) wSched[t] = '0;
    wSched[0]  = 32'h61626380;
    wSched[15] = 32'h00000018;
    for (int t = 16; t < R; t++) begin
      wSched[t] = (ror(wSched[t-2], 17) ^ ror(wSched[t-2], 19) ^ (wSched[t-2] >> 10)) + wSched[t-7]
                + (ror(wSched[t-15], 7) ^ ror(wSched[t-15], 18) ^ (wSched[t-15] >> 3)) + wSched[t-16];
    end

    // Reset state.
    applyStimulus();
    applyStimulus();
    RST = 1'b0;
    applyStimulus();
    checkOutput("resetHash", hashO, '0);
    checkOutput("resetWork", workO, '0);
    checkOutput("resetRound", 256'(roundO), 256'(0));
    checkOutput("resetBusy", 256'(busyO), 256'(0));
    checkOutput("resetDone", 256'(doneO), 256'(0));

    // Zero block: latency and all-zero digest.
    runBlock(0, -1, 0, lat);
    checkOutput("zeroLatency", 256'(lat), 256'(R + 2));
    checkOutput("zeroHash", hashO, '0);

    // init_i and blk_start_i together: load wins, stay idle.
    initI     = 1'b1;
    ivI       = IV_256;
    blkStartI = 1'b1;
    applyStimulus();
    initI     = 1'b0;
    blkStartI = 1'b0;
    checkOutput("initStartBusy", 256'(busyO), 256'(0));
    checkOutput("initStartHash", hashO, IV_256);

    // Known answer "abc".
    runBlock(1, -1, 0, lat);
    checkOutput("abcDigest", hashO, ABC_DIGEST);
    checkOutput("abcLatency", 256'(lat), 256'(R + 2));
    applyStimulus();
    checkOutput("donePulseOnce", 256'(doneO), 256'(0));

    // Stall of 5 cycles at round 20.
    loadIv(IV_256);
    runBlock(1, 20, 5, lat);
    checkOutput("stallLatency", 256'(lat), 256'(R + 7));
    checkOutput("stallDigest", hashO, ABC_DIGEST);

    // init_i during RUN is ignored.
    loadIv(IV_256);
    startBlock();
    for (int i = 0; i < 3; i++) begin
      initI  = 1'b1;
      ivI    = randWide();
      rndEnI = 1'b1;
      setRoundInputs(1);
      applyStimulus();
    end
    initI = 1'b0;
    checkOutput("initDuringRun", hashO, IV_256);
    lat = 0;
    finishBlock(1, -1, 0, lat);
    checkOutput("initRunDigest", hashO, ABC_DIGEST);

    // Back-to-back: blk_start_i in the done cycle.
    blkStartI = 1'b1;
    applyStimulus();
    blkStartI = 1'b0;
    checkOutput("b2bBusy", 256'(busyO), 256'(1));
    checkOutput("b2bRound", 256'(roundO), 256'(0));
    checkOutput("b2bWork", workO, ABC_DIGEST);
    lat = 0;
    finishBlock(0, -1, 0, lat);

    // Wrap-around arithmetic.
    loadIv({8{32'hffffffff}});
    runBlock(2, -1, 0, lat);
    checkOutput("wrapWork", workO, {{4{32'h00000001}}, {4{32'h00000002}}});
    checkOutput("wrapHash", hashO, {{4{32'h00000000}}, {4{32'h00000001}}});

    // Random blocks with stalls and spurious control inputs.
    for (int n = 0; n < 4; n++) begin
      loadIv(randWide());
      runBlock(3, -1, 0, lat);
    end

    // Reset mid-block at round 30.
    loadIv(IV_256);
    startBlock();
    guard = 0;
    while (mRound < 30 && guard < 200) begin
      rndEnI = 1'b1;
      setRoundInputs(1);
      applyStimulus();
      guard++;
    end
    checkOutput("reachRound30", 256'(roundO), 256'(30));
    rndEnI = 1'b0;
    RST    = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncHash", hashO, '0);
    checkOutput("asyncWork", workO, '0);
    checkOutput("asyncRound", 256'(roundO), 256'(0));
    checkOutput("asyncBusy", 256'(busyO), 256'(0));
    checkOutput("asyncDone", 256'(doneO), 256'(0));
    applyStimulus();
    RST = 1'b0;
    applyStimulus();
    startBlock();
    checkOutput("resetReload", workO, '0);
    checkOutput("resetReloadBusy", 256'(busyO), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_state_regbank.md
Name: sha_state_regbank

Overview:
- Parametrised state register bank for the SHA-2 compression core.
- Holds the eight chaining words H0..H7 and the eight working variables a..h.
- Sequences one message block: loads a..h from H, applies ROUNDS round updates using externally computed T1/T2, then performs the final modular accumulate H += a..h.
- Sits between the round-function datapath (which supplies T1/T2) and the digest output.
- WIDTH/ROUNDS select SHA-256 (32/64) or SHA-512 (64/80).

Parameters:
- WIDTH, 32, word width in bits (32 or 64).
- ROUNDS, 64, rounds per block (64 or 80).
- RW, $clog2(ROUNDS), width of the round counter (derived, do not override).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- init_i  input  1  load H0..H7 from iv_i (IDLE only).
- iv_i  input  8*WIDTH  initial hash value; H0 in MSBs.
- blk_start_i  input  1  start one block (IDLE only).
- rnd_en_i  input  1  T1/T2 valid, advance one round (RUN only).
- t1_i  input  WIDTH  round T1.
- t2_i  input  WIDTH  round T2.
- work_o  output  8*WIDTH  a..h registers; a in MSBs.
- hash_o  output  8*WIDTH  H0..H7 registers; H0 in MSBs.
- round_o  output  RW  index of the next round to execute.
- busy_o  output  1  high when state is not IDLE.
- done_o  output  1  one-cycle pulse when hash_o holds the new value.

Behaviour:
- Reset (async, RST=1): H0..H7=0, a..h=0, round_o=0, state=IDLE, done_o=0, busy_o=0. RST asserted mid-block aborts the block, with no partial accumulate.
- States: IDLE, RUN, FINAL. busy_o is decoded from the state register.
- IDLE:
  - init_i=1: H <= iv_i. This takes priority; a blk_start_i in the same cycle is ignored.
  - else blk_start_i=1: a..h <= H0..H7, round_o <= 0, go to RUN.
  - rnd_en_i is ignored.
- RUN, on each edge with rnd_en_i=1:
  - a <= t1+t2; b <= a; c <= b; d <= c; e <= d+t1; f <= e; g <= f; h <= g.
  - round_o <= round_o+1.
  - If round_o==ROUNDS-1, go to FINAL and set round_o <= 0.
- RUN with rnd_en_i=0: all registers hold. Stalls are unlimited.
- RUN and FINAL ignore init_i and blk_start_i; no queuing.
- FINAL (exactly one cycle): Hi <= Hi + work_i for i=0..7; a..h hold; go to IDLE; done_o <= 1.
- done_o is registered and high for exactly the first IDLE cycle after FINAL; otherwise 0. A blk_start_i in that cycle is accepted (back-to-back blocks).
- Arithmetic: all additions are modulo 2^WIDTH; carries are discarded; no saturation.
- Latency: blk_start edge -> ROUNDS rnd_en edges -> 1 FINAL edge -> done_o. With rnd_en_i held high, done_o rises ROUNDS+2 cycles after blk_start_i is sampled.
- hash_o changes only on init and FINAL edges. work_o changes only on blk_start and round edges.

Test Plan:
- Reset state: assert RST for 2 cycles, then release -> all outputs 0, busy_o=0. Pulse blk_start_i with rnd_en_i=1 held, t1=t2=0 -> done_o after 66 cycles, hash_o all 0.
- Known answer: init_i with iv_i=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; bench closes the loop by computing t1/t2 from work_o for the padded block "abc"; rnd_en_i=1 -> hash_o=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done_o pulses once.
- Wrap-around: iv_i all ffffffff; t1=1, t2=0 on all 64 rounds -> work_o a..d=00000001, e..h=00000002. After FINAL: hash_o H0..H3=00000000, H4..H7=00000001.
- Stall: in the "abc" run, drop rnd_en_i for 5 cycles at round_o=20 -> round_o holds at 20, work_o is stable, done_o is delayed by exactly 5 cycles, digest is unchanged.
- Priority and ignore:
  - init_i and blk_start_i together in IDLE -> H loaded, state stays IDLE.
  - init_i during RUN -> hash_o unchanged.
  - blk_start_i in the done_o cycle -> new block starts and round_o=0.
- Reset mid-block: assert RST at round_o=30 -> all outputs 0 immediately (async). Next blk_start_i loads a..h=0.
